axil_wb_bridge: RTL

AXI4-Lite slave to Wishbone classic master bridge; the return path of the CPU-side Wishbone-to-AXI-Lite bridge. It lets an AXI-Lite master (host/PCIe bridge, debug master) reach Wishbone-attached peripherals on the NEORV32 side of the design. It handles one outstanding transaction at a time, maps Wishbone ack/err onto AXI responses, and arbitrates simultaneous read and write requests round-robin.

---
 rtl/axil_wb_pkg.sv | 17 +
 rtl/axil_wb_timeout.sv | 30 +++
 rtl/axil_wb_bridge.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/axil_wb_pkg.sv
// Shared types and response codes for the AXI-Lite to Wishbone bridge.
// Optional timeout logic is enabled with AXIL_WB_TIMEOUT_EN.
package axil_wb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WB_WR,
    WB_RD,
    B_RESP,
    R_RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_wb_timeout.sv
// Wishbone stall watchdog: clears on accept, counts while enabled.
// Only instantiated when AXIL_WB_TIMEOUT_EN is defined.
module axil_wb_timeout #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [15:0] LAST = 16'(LIMIT - 1);

  logic [15:0] cnt;

  // Count bus cycles, saturating at the last one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != LAST) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign expire = en && (cnt == LAST);

endmodule

// File: rtl/axil_wb_bridge.sv
// AXI4-Lite slave to Wishbone classic master, one transaction at a time.
// Define AXIL_WB_TIMEOUT_EN to abort silent Wishbone cycles with DECERR.
module axil_wb_bridge
  import axil_wb_pkg::*;
#(
  parameter int AW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] s_axi_awaddr,
  input  logic [2:0]    s_axi_awprot,
  input  logic          s_axi_awvalid,
  output logic          s_axi_awready,
  input  logic [31:0]   s_axi_wdata,
  input  logic [3:0]    s_axi_wstrb,
  input  logic          s_axi_wvalid,
  output logic          s_axi_wready,
  output logic [1:0]    s_axi_bresp,
  output logic          s_axi_bvalid,
  input  logic          s_axi_bready,
  input  logic [AW-1:0] s_axi_araddr,
  input  logic [2:0]    s_axi_arprot,
  input  logic          s_axi_arvalid,
  output logic          s_axi_arready,
  output logic [31:0]   s_axi_rdata,
  output logic [1:0]    s_axi_rresp,
  output logic          s_axi_rvalid,
  input  logic          s_axi_rready,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [AW-1:0] wb_adr_o,
  output logic [31:0]   wb_dat_o,
  output logic [3:0]    wb_sel_o,
  input  logic [31:0]   wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i
);

  state_t state, state_nxt;

  logic          aw_rdy, ar_rdy, rr_wr;
  logic [AW-1:0] adr_q;
  logic [31:0]   dat_q, rdata_q;
  logic [3:0]    sel_q;
  logic [1:0]    resp_q;

  logic idle, in_wb, wr_req, rd_req;
  logic grant_wr, grant_rd, wr_hs, rd_hs;
  logic ack, err, tmo, term;
  logic unused;

  assign idle   = (state == IDLE);
  assign in_wb  = (state == WB_WR) || (state == WB_RD);
  assign wr_req = s_axi_awvalid & s_axi_wvalid;
  assign rd_req = s_axi_arvalid;

  // Ready is registered: grant one cycle, handshake the next.
  // rr_wr set means the write won last, so a contest goes to the read.
  assign grant_wr = idle & ~aw_rdy & ~ar_rdy & wr_req
                  & (~rd_req | ~rr_wr);
  assign grant_rd = idle & ~aw_rdy & ~ar_rdy & rd_req
                  & (~wr_req | rr_wr);

  assign wr_hs = aw_rdy & s_axi_awvalid & s_axi_wvalid;
  assign rd_hs = ar_rdy & s_axi_arvalid;

  assign ack  = in_wb & wb_ack_i;
  assign err  = in_wb & wb_err_i;
  assign term = ack | err | tmo;

`ifdef AXIL_WB_TIMEOUT_EN
  logic expire;

  axil_wb_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk_i),
    .rst    (rst_i),
    .clr    (wr_hs | rd_hs),
    .en     (in_wb),
    .expire (expire)
  );

  assign tmo = in_wb & expire;
`else
  assign tmo = 1'b0;
`endif

  assign unused = ^{s_axi_awprot, s_axi_arprot, TIMEOUT_CYCLES > 0};

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (wr_hs)      state_nxt = WB_WR;
        else if (rd_hs) state_nxt = WB_RD;
      end
      WB_WR:  if (term)         state_nxt = B_RESP;
      WB_RD:  if (term)         state_nxt = R_RESP;
      B_RESP: if (s_axi_bready) state_nxt = IDLE;
      R_RESP: if (s_axi_rready) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Grant, request latch and response capture.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aw_rdy  <= 1'b0;
      ar_rdy  <= 1'b0;
      rr_wr   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      resp_q  <= RESP_OKAY;
      rdata_q <= '0;
    end else begin
      aw_rdy <= grant_wr;
      ar_rdy <= grant_rd;
      if (grant_wr)      rr_wr <= 1'b1;
      else if (grant_rd) rr_wr <= 1'b0;
      if (wr_hs) begin
        adr_q <= s_axi_awaddr;
        dat_q <= s_axi_wdata;
        sel_q <= s_axi_wstrb;
      end else if (rd_hs) begin
        adr_q <= s_axi_araddr;
        sel_q <= 4'hF;
      end
      if (term) begin
        if (err)      resp_q <= RESP_SLVERR;
        else if (ack) resp_q <= RESP_OKAY;
        else          resp_q <= RESP_DECERR;
        if (state == WB_RD)
          rdata_q <= (ack & ~err) ? wb_dat_i : 32'h0;
      end
    end
  end

  // Outputs decode from flops only.
  always_comb begin
    s_axi_awready = aw_rdy;
    s_axi_wready  = aw_rdy;
    s_axi_arready = ar_rdy;
    s_axi_bvalid  = (state == B_RESP);
    s_axi_bresp   = resp_q;
    s_axi_rvalid  = (state == R_RESP);
    s_axi_rresp   = resp_q;
    s_axi_rdata   = rdata_q;
    wb_cyc_o      = in_wb;
    wb_stb_o      = in_wb;
    wb_we_o       = (state == WB_WR);
    wb_adr_o      = adr_q;
    wb_dat_o      = dat_q;
    wb_sel_o      = sel_q;
  end

endmodule
